// File: rtl/OoO_pkg.sv
`default_nettype none
// ============================================================================
// Module   : OoO_pkg
// Brief    : Shared sizes and record types for the scoreboard slice.
// Revision : 1.0
// ============================================================================
package OoO_pkg;

    localparam int ScoreboardDepth = 4;
    localparam int WriteBackPorts  = 2;
    localparam int SbIdxW          = $clog2(ScoreboardDepth);
    localparam int SbCntW          = $clog2(ScoreboardDepth + 1);

    typedef struct packed {
        logic [31:0]       pc;
        logic [3:0]        op;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [SbIdxW-1:0] idx;
        logic              valid;
        logic [31:0]       result;
    } decoder_t;

    typedef struct packed {
        logic              valid;
        logic [SbIdxW-1:0] idx;
        logic [31:0]       data;
    } wb_port_t;

    typedef struct packed {
        logic [ScoreboardDepth-1:0]     issued;
        decoder_t [ScoreboardDepth-1:0] instr;
        wb_port_t [WriteBackPorts-1:0]  wb;
    } forwarding_t;

    typedef struct packed {
        logic     alloc;
        logic     issued;
        decoder_t instr;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_if
// Brief    : Decode, issue, writeback, forwarding and commit bundle.
// Revision : 1.0
// ============================================================================
interface scoreboard_if;
    import OoO_pkg::*;

    decoder_t                                decoded_instr;
    logic                                    decoded_valid;
    logic                                    decoded_ready;
    decoder_t                                issue_instr;
    logic                                    issue_valid;
    logic                                    issue_ready;
    forwarding_t                             fwd;
    logic [WriteBackPorts-1:0][SbIdxW-1:0]   wb_idx;
    logic [WriteBackPorts-1:0][31:0]         wb_data;
    logic [WriteBackPorts-1:0]               wb_valid;
    decoder_t                                commit_instr;
    logic                                    commit_valid;
    logic                                    commit_ack;

    modport master (
        output decoded_instr, decoded_valid, issue_ready,
        output wb_idx, wb_data, wb_valid, commit_ack,
        input  decoded_ready, issue_instr, issue_valid,
        input  fwd, commit_instr, commit_valid
    );

    modport slave (
        input  decoded_instr, decoded_valid, issue_ready,
        input  wb_idx, wb_data, wb_valid, commit_ack,
        output decoded_ready, issue_instr, issue_valid,
        output fwd, commit_instr, commit_valid
    );

endinterface
`default_nettype wire

// File: rtl/scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard
// Brief    : In-order allocate/issue/commit buffer with writeback collection.
//            Optional SCOREBOARD_WB_BYPASS_EN lets commit see same-cycle writebacks.
// Revision : 1.0
// ============================================================================
module scoreboard
    import OoO_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    scoreboard_if.slave   sb
);

    sb_entry_t [ScoreboardDepth-1:0] mem_q, mem_d;
    logic [SbIdxW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [SbIdxW-1:0] issue_ptr_q, issue_ptr_d;
    logic [SbIdxW-1:0] commit_ptr_q, commit_ptr_d;
    logic [SbCntW-1:0] count_q, count_d;

    logic        alloc_hs, issue_hs, commit_hs;
    logic        byp_hit;
    logic [31:0] byp_data;

    always_comb begin
        mem_d        = mem_q;
        alloc_ptr_d  = alloc_ptr_q;
        issue_ptr_d  = issue_ptr_q;
        commit_ptr_d = commit_ptr_q;
        byp_hit      = 1'b0;
        byp_data     = '0;

        sb.decoded_ready = (count_q != SbCntW'(ScoreboardDepth)) && !flush;
        sb.issue_valid   = mem_q[issue_ptr_q].alloc && !mem_q[issue_ptr_q].issued;
        sb.issue_instr   = mem_q[issue_ptr_q].instr;

`ifdef SCOREBOARD_WB_BYPASS_EN
        // Descending walk so the lowest matching port is the one left standing.
        for (int p = WriteBackPorts - 1; p >= 0; p--) begin
            if (sb.wb_valid[p] && (sb.wb_idx[p] == commit_ptr_q)) begin
                byp_hit  = 1'b1;
                byp_data = sb.wb_data[p];
            end
        end
`endif

        sb.commit_instr = mem_q[commit_ptr_q].instr;
        sb.commit_valid = mem_q[commit_ptr_q].issued &&
                          (mem_q[commit_ptr_q].instr.valid || byp_hit);
        if (byp_hit && mem_q[commit_ptr_q].issued) begin
            sb.commit_instr.result = byp_data;
            sb.commit_instr.valid  = 1'b1;
        end

        alloc_hs  = sb.decoded_valid && sb.decoded_ready;
        issue_hs  = sb.issue_valid && sb.issue_ready;
        commit_hs = sb.commit_valid && sb.commit_ack;

        if (alloc_hs) begin
            mem_d[alloc_ptr_q].alloc       = 1'b1;
            mem_d[alloc_ptr_q].issued      = 1'b0;
            mem_d[alloc_ptr_q].instr       = sb.decoded_instr;
            mem_d[alloc_ptr_q].instr.idx   = alloc_ptr_q;
            mem_d[alloc_ptr_q].instr.valid = 1'b0;
            alloc_ptr_d = alloc_ptr_q + SbIdxW'(1);
        end

        if (issue_hs) begin
            mem_d[issue_ptr_q].issued = 1'b1;
            issue_ptr_d = issue_ptr_q + SbIdxW'(1);
        end

        // Lowest port index wins a same-slot collision by writing last.
        for (int p = WriteBackPorts - 1; p >= 0; p--) begin
            if (sb.wb_valid[p] && mem_q[sb.wb_idx[p]].issued) begin
                mem_d[sb.wb_idx[p]].instr.result = sb.wb_data[p];
                mem_d[sb.wb_idx[p]].instr.valid  = 1'b1;
            end
        end

        if (commit_hs) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
            if (byp_hit) begin
                mem_d[commit_ptr_q].instr = mem_q[commit_ptr_q].instr;
            end
`endif
            mem_d[commit_ptr_q].alloc  = 1'b0;
            mem_d[commit_ptr_q].issued = 1'b0;
            commit_ptr_d = commit_ptr_q + SbIdxW'(1);
        end

        count_d = count_q + SbCntW'(alloc_hs) - SbCntW'(commit_hs);

        if (flush) begin
            mem_d        = '0;
            alloc_ptr_d  = '0;
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
        end

        for (int s = 0; s < ScoreboardDepth; s++) begin
            sb.fwd.issued[s] = mem_q[s].issued;
            sb.fwd.instr[s]  = mem_q[s].instr;
        end
        for (int p = 0; p < WriteBackPorts; p++) begin
            sb.fwd.wb[p].valid = sb.wb_valid[p];
            sb.fwd.wb[p].idx   = sb.wb_idx[p];
            sb.fwd.wb[p].data  = sb.wb_data[p];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q        <= '0;
            alloc_ptr_q  <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            mem_q        <= mem_d;
            alloc_ptr_q  <= alloc_ptr_d;
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard
// Brief    : Self-checking bench for scoreboard with a commit-result queue.
// Revision : 1.0
// ============================================================================
module tb_scoreboard;
    import OoO_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    scoreboard_if sb_if ();

    scoreboard dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .sb    (sb_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [SbIdxW-1:0] idx;
        logic [31:0]       result;
    } exp_t;

    exp_t commit_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    function automatic decoder_t mk_instr(input logic [31:0] pc);
        decoder_t d;
        d        = '0;
        d.pc     = pc;
        d.op     = 4'h3;
        d.rd     = 5'd7;
        d.rs1    = 5'd1;
        d.rs2    = 5'd2;
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        sb_if.decoded_instr = '0;
        sb_if.decoded_valid = 1'b0;
        sb_if.issue_ready   = 1'b0;
        sb_if.wb_idx        = '0;
        sb_if.wb_data       = '0;
        sb_if.wb_valid      = '0;
        sb_if.commit_ack    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (sb_if.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%0b exp=0", sb_if.issue_valid); end
        checks++; if (sb_if.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got=%0b exp=0", sb_if.commit_valid); end
        checks++; if (sb_if.decoded_ready !== 1'b1) begin errors++; $display("FAIL reset_decoded_ready got=%0b exp=1", sb_if.decoded_ready); end
        checks++; if (sb_if.fwd.issued !== '0) begin errors++; $display("FAIL reset_fwd_issued got=%0h exp=0", sb_if.fwd.issued); end
        checks++; if (sb_if.fwd.instr !== '0) begin errors++; $display("FAIL reset_fwd_instr got=%0h exp=0", sb_if.fwd.instr); end
        checks++; if (sb_if.issue_instr !== '0) begin errors++; $display("FAIL reset_issue_instr got=%0h exp=0", sb_if.issue_instr); end
        checks++; if (sb_if.commit_instr !== '0) begin errors++; $display("FAIL reset_commit_instr got=%0h exp=0", sb_if.commit_instr); end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            sb_if.decoded_instr = mk_instr(32'h100 + 32'(4 * i));
            sb_if.decoded_valid = 1'b1;
            @(negedge clock);
            checks++; if (sb_if.decoded_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got=%0b exp=1", i, sb_if.decoded_ready); end
            if (i == 0) begin
                checks++; if (sb_if.issue_valid !== 1'b0) begin errors++; $display("FAIL fill_issue_early got=%0b exp=0", sb_if.issue_valid); end
            end
            tick();
        end
        sb_if.decoded_valid = 1'b0;
        @(negedge clock);
        checks++; if (sb_if.decoded_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%0b exp=0", sb_if.decoded_ready); end
        checks++; if (sb_if.issue_valid !== 1'b1) begin errors++; $display("FAIL fill_issue_valid got=%0b exp=1", sb_if.issue_valid); end
        checks++; if (sb_if.issue_instr.idx !== SbIdxW'(0)) begin errors++; $display("FAIL fill_issue_idx got=%0d exp=0", sb_if.issue_instr.idx); end
        checks++; if (sb_if.issue_instr.pc !== 32'h100) begin errors++; $display("FAIL fill_issue_pc got=%0h exp=100", sb_if.issue_instr.pc); end
        checks++; if (dut.count_q !== SbCntW'(4)) begin errors++; $display("FAIL fill_count got=%0d exp=4", dut.count_q); end
        checks++; if (sb_if.commit_valid !== 1'b0) begin errors++; $display("FAIL fill_commit_valid got=%0b exp=0", sb_if.commit_valid); end
        tick();
    endtask

    task automatic test_writeback();
        sb_if.issue_ready = 1'b1;
        @(negedge clock);
        checks++; if (sb_if.issue_instr.idx !== SbIdxW'(0)) begin errors++; $display("FAIL wb_issue_idx got=%0d exp=0", sb_if.issue_instr.idx); end
        tick();
        sb_if.issue_ready = 1'b0;
        @(negedge clock);
        checks++; if (sb_if.fwd.issued !== 4'b0001) begin errors++; $display("FAIL wb_fwd_issued got=%b exp=0001", sb_if.fwd.issued); end
        tick();
        sb_if.wb_valid   = 2'b01;
        sb_if.wb_idx[0]  = SbIdxW'(0);
        sb_if.wb_data[0] = 32'hDEADBEEF;
        commit_q.push_back('{idx: SbIdxW'(0), result: 32'hDEADBEEF});
        @(negedge clock);
        checks++; if (sb_if.fwd.wb[0].data !== 32'hDEADBEEF || sb_if.fwd.wb[0].valid !== 1'b1) begin errors++; $display("FAIL wb_fwd_pass got=%0b/%0h exp=1/deadbeef", sb_if.fwd.wb[0].valid, sb_if.fwd.wb[0].data); end
`ifdef SCOREBOARD_WB_BYPASS_EN
        checks++; if (sb_if.commit_valid !== 1'b1) begin errors++; $display("FAIL wb_bypass_commit_valid got=%0b exp=1", sb_if.commit_valid); end
        checks++; if (sb_if.commit_instr.result !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_bypass_result got=%0h exp=deadbeef", sb_if.commit_instr.result); end
`else
        checks++; if (sb_if.commit_valid !== 1'b0) begin errors++; $display("FAIL wb_commit_early got=%0b exp=0", sb_if.commit_valid); end
`endif
        tick();
        sb_if.wb_valid = '0;
        @(negedge clock);
        checks++; if (sb_if.fwd.instr[0].valid !== 1'b1) begin errors++; $display("FAIL wb_fwd_valid got=%0b exp=1", sb_if.fwd.instr[0].valid); end
        checks++; if (sb_if.commit_valid !== 1'b1) begin errors++; $display("FAIL wb_commit_valid got=%0b exp=1", sb_if.commit_valid); end
        checks++; if (sb_if.commit_instr.result !== commit_q[0].result) begin errors++; $display("FAIL wb_commit_result got=%0h exp=%0h", sb_if.commit_instr.result, commit_q[0].result); end
        tick();
    endtask

    task automatic test_wb_priority();
        sb_if.issue_ready = 1'b1;
        @(negedge clock);
        checks++; if (sb_if.issue_instr.idx !== SbIdxW'(1)) begin errors++; $display("FAIL prio_issue_idx got=%0d exp=1", sb_if.issue_instr.idx); end
        tick();
        sb_if.issue_ready = 1'b0;
        sb_if.wb_valid    = 2'b11;
        sb_if.wb_idx[0]   = SbIdxW'(1);
        sb_if.wb_idx[1]   = SbIdxW'(1);
        sb_if.wb_data[0]  = 32'd5;
        sb_if.wb_data[1]  = 32'd9;
        commit_q.push_back('{idx: SbIdxW'(1), result: 32'd5});
        tick();
        sb_if.wb_valid = '0;
        @(negedge clock);
        checks++; if (sb_if.fwd.instr[1].valid !== 1'b1) begin errors++; $display("FAIL prio_valid got=%0b exp=1", sb_if.fwd.instr[1].valid); end
        checks++; if (sb_if.fwd.instr[1].result !== 32'd5) begin errors++; $display("FAIL prio_result got=%0d exp=5", sb_if.fwd.instr[1].result); end
        tick();
    endtask

    task automatic test_wb_ignored();
        sb_if.wb_valid   = 2'b01;
        sb_if.wb_idx[0]  = SbIdxW'(2);
        sb_if.wb_data[0] = 32'd77;
        tick();
        sb_if.wb_valid = '0;
        @(negedge clock);
        checks++; if (sb_if.fwd.instr[2].valid !== 1'b0) begin errors++; $display("FAIL ignored_valid got=%0b exp=0", sb_if.fwd.instr[2].valid); end
        checks++; if (sb_if.fwd.instr[2].result !== 32'd0) begin errors++; $display("FAIL ignored_result got=%0d exp=0", sb_if.fwd.instr[2].result); end
        tick();
    endtask

    task automatic test_full_commit();
        sb_if.decoded_instr = mk_instr(32'h500);
        sb_if.decoded_valid = 1'b1;
        sb_if.commit_ack    = 1'b1;
        @(negedge clock);
        e = commit_q.pop_front();
        checks++; if (sb_if.decoded_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", sb_if.decoded_ready); end
        checks++; if (sb_if.commit_valid !== 1'b1 || sb_if.commit_instr.result !== e.result) begin errors++; $display("FAIL full_commit got=%0b/%0h exp=1/%0h", sb_if.commit_valid, sb_if.commit_instr.result, e.result); end
        tick();
        sb_if.decoded_valid = 1'b0;
        sb_if.commit_ack    = 1'b0;
        @(negedge clock);
        checks++; if (dut.count_q !== SbCntW'(3)) begin errors++; $display("FAIL full_count got=%0d exp=3", dut.count_q); end
        checks++; if (sb_if.decoded_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got=%0b exp=1", sb_if.decoded_ready); end
        checks++; if (sb_if.issue_instr.idx !== SbIdxW'(2)) begin errors++; $display("FAIL full_issue_idx got=%0d exp=2", sb_if.issue_instr.idx); end
        tick();
        sb_if.commit_ack = 1'b1;
        @(negedge clock);
        e = commit_q.pop_front();
        checks++; if (sb_if.commit_valid !== 1'b1 || sb_if.commit_instr.idx !== e.idx || sb_if.commit_instr.result !== e.result) begin errors++; $display("FAIL full_commit1 got=%0b/%0d/%0h exp=1/%0d/%0h", sb_if.commit_valid, sb_if.commit_instr.idx, sb_if.commit_instr.result, e.idx, e.result); end
        tick();
        sb_if.commit_ack = 1'b0;
        for (int s = 2; s < 4; s++) begin
            sb_if.issue_ready = 1'b1;
            @(negedge clock);
            checks++; if (sb_if.issue_valid !== 1'b1 || sb_if.issue_instr.idx !== SbIdxW'(s)) begin errors++; $display("FAIL drain_issue got=%0b/%0d exp=1/%0d", sb_if.issue_valid, sb_if.issue_instr.idx, s); end
            tick();
            sb_if.issue_ready = 1'b0;
            sb_if.wb_valid    = 2'b01;
            sb_if.wb_idx[0]   = SbIdxW'(s);
            sb_if.wb_data[0]  = 32'hA0 + 32'(s);
            commit_q.push_back('{idx: SbIdxW'(s), result: 32'hA0 + 32'(s)});
            tick();
            sb_if.wb_valid   = '0;
            sb_if.commit_ack = 1'b1;
            @(negedge clock);
            e = commit_q.pop_front();
            checks++; if (sb_if.commit_valid !== 1'b1 || sb_if.commit_instr.idx !== e.idx || sb_if.commit_instr.result !== e.result) begin errors++; $display("FAIL drain_commit got=%0b/%0d/%0h exp=1/%0d/%0h", sb_if.commit_valid, sb_if.commit_instr.idx, sb_if.commit_instr.result, e.idx, e.result); end
            tick();
            sb_if.commit_ack = 1'b0;
        end
        @(negedge clock);
        checks++; if (sb_if.issue_valid !== 1'b0 || sb_if.commit_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b/%0b exp=0/0", sb_if.issue_valid, sb_if.commit_valid); end
        checks++; if (dut.count_q !== SbCntW'(0)) begin errors++; $display("FAIL drain_count got=%0d exp=0", dut.count_q); end
        tick();
    endtask

    task automatic test_wrap();
        logic [SbIdxW-1:0] xi;
        for (int r = 0; r < 9; r++) begin
            xi = SbIdxW'(r % ScoreboardDepth);
            sb_if.decoded_instr = mk_instr(32'h1000 + 32'(r));
            sb_if.decoded_valid = 1'b1;
            @(negedge clock);
            checks++; if (sb_if.decoded_ready !== 1'b1 || sb_if.issue_valid !== 1'b0) begin errors++; $display("FAIL wrap_alloc_%0d got=%0b/%0b exp=1/0", r, sb_if.decoded_ready, sb_if.issue_valid); end
            tick();
            sb_if.decoded_valid = 1'b0;
            sb_if.issue_ready   = 1'b1;
            @(negedge clock);
            checks++; if (sb_if.issue_valid !== 1'b1 || sb_if.issue_instr.idx !== xi || sb_if.issue_instr.pc !== 32'h1000 + 32'(r)) begin errors++; $display("FAIL wrap_issue_%0d got=%0b/%0d/%0h exp=1/%0d/%0h", r, sb_if.issue_valid, sb_if.issue_instr.idx, sb_if.issue_instr.pc, xi, 32'h1000 + 32'(r)); end
            tick();
            sb_if.issue_ready = 1'b0;
            sb_if.wb_valid    = 2'b10;
            sb_if.wb_idx[1]   = xi;
            sb_if.wb_data[1]  = 32'(r * 3 + 1);
            commit_q.push_back('{idx: xi, result: 32'(r * 3 + 1)});
            tick();
            sb_if.wb_valid   = '0;
            sb_if.commit_ack = 1'b1;
            @(negedge clock);
            e = commit_q.pop_front();
            checks++; if (sb_if.commit_valid !== 1'b1 || sb_if.commit_instr.idx !== e.idx || sb_if.commit_instr.result !== e.result) begin errors++; $display("FAIL wrap_commit_%0d got=%0b/%0d/%0h exp=1/%0d/%0h", r, sb_if.commit_valid, sb_if.commit_instr.idx, sb_if.commit_instr.result, e.idx, e.result); end
            tick();
            sb_if.commit_ack = 1'b0;
        end
    endtask

    task automatic test_flush();
        logic any_valid;
        for (int i = 0; i < 3; i++) begin
            sb_if.decoded_instr = mk_instr(32'h2000 + 32'(i));
            sb_if.decoded_valid = 1'b1;
            tick();
        end
        sb_if.decoded_valid = 1'b0;
        sb_if.issue_ready   = 1'b1;
        tick();
        sb_if.issue_ready = 1'b0;
        sb_if.wb_valid    = 2'b01;
        sb_if.wb_idx[0]   = SbIdxW'(1);
        sb_if.wb_data[0]  = 32'h42;
        tick();
        sb_if.wb_valid      = '0;
        flush               = 1'b1;
        sb_if.decoded_instr = mk_instr(32'h2FFF);
        sb_if.decoded_valid = 1'b1;
        @(negedge clock);
        checks++; if (sb_if.decoded_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", sb_if.decoded_ready); end
        tick();
        flush               = 1'b0;
        sb_if.decoded_valid = 1'b0;
        commit_q.delete();
        @(negedge clock);
        any_valid = 1'b0;
        for (int s = 0; s < ScoreboardDepth; s++) any_valid |= sb_if.fwd.instr[s].valid;
        checks++; if (sb_if.fwd.issued !== '0 || any_valid !== 1'b0) begin errors++; $display("FAIL flush_bits got=%b/%0b exp=0000/0", sb_if.fwd.issued, any_valid); end
        checks++; if (dut.count_q !== SbCntW'(0)) begin errors++; $display("FAIL flush_count got=%0d exp=0", dut.count_q); end
        checks++; if (sb_if.issue_valid !== 1'b0 || sb_if.commit_valid !== 1'b0 || sb_if.decoded_ready !== 1'b1) begin errors++; $display("FAIL flush_hs got=%0b/%0b/%0b exp=0/0/1", sb_if.issue_valid, sb_if.commit_valid, sb_if.decoded_ready); end
        tick();
        sb_if.decoded_instr = mk_instr(32'h3000);
        sb_if.decoded_valid = 1'b1;
        tick();
        sb_if.decoded_valid = 1'b0;
        @(negedge clock);
        checks++; if (sb_if.issue_valid !== 1'b1 || sb_if.issue_instr.idx !== SbIdxW'(0) || sb_if.issue_instr.pc !== 32'h3000) begin errors++; $display("FAIL flush_realloc got=%0b/%0d/%0h exp=1/0/3000", sb_if.issue_valid, sb_if.issue_instr.idx, sb_if.issue_instr.pc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_writeback();
        test_wb_priority();
        test_wb_ignored();
        test_full_commit();
        test_wrap();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
